// File: rtl/mem_responder.sv
// mem_responder: byte-addressed big-endian word memory served over valid/ready with configurable wait states
//
// Ports:
//   clk         in   rising-edge clock
//   rst         in   asynchronous reset, active-high
//   req_valid   in   request present
//   req_ready   out  responder idle and able to accept a request
//   req_write   in   1 = write, 0 = read
//   req_addr    in   byte address of the word's most significant byte
//   req_wdata   in   write data
//   resp_valid  out  response present
//   resp_ready  in   requester accepts the response
//   resp_rdata  out  read data, 0 for a write response
module mem_responder #(
    parameter int ADDRESS_SIZE = 11,
    parameter int WORD_SIZE    = 64,
    parameter int WAIT_CYCLES  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDRESS_SIZE-1:0] req_addr,
    input  logic [WORD_SIZE-1:0]    req_wdata,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [WORD_SIZE-1:0]    resp_rdata
);
    localparam int NB = WORD_SIZE / 8;
    localparam int CW = WAIT_CYCLES > 0 ? $clog2(WAIT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    write_q, write_d;
    logic [ADDRESS_SIZE-1:0] addr_q, addr_d;
    logic [WORD_SIZE-1:0]    wdata_q, wdata_d;
    logic [WORD_SIZE-1:0]    rdata_q, rdata_d;
    logic [WORD_SIZE-1:0]    rd_word;
    logic                    access;
    logic [7:0]              mem_q [2**ADDRESS_SIZE];

    // Byte g of the word lives at addr+g; the address wraps modulo the memory size.
    for (genvar g = 0; g < NB; g++) begin : g_rd
        assign rd_word[WORD_SIZE-1-8*g -: 8] = mem_q[addr_q + ADDRESS_SIZE'(g)];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        access  = 1'b0;
        case (state_q)
            IDLE: if (req_valid) begin
                write_d = req_write;
                addr_d  = req_addr;
                wdata_d = req_wdata;
                cnt_d   = CW'(WAIT_CYCLES);
                state_d = BUSY;
            end
            BUSY: if (cnt_q != '0) begin
                cnt_d = cnt_q - CW'(1);
            end else begin
                access  = 1'b1;
                rdata_d = write_q ? '0 : rd_word;
                state_d = RESP;
            end
            RESP: state_d = resp_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Storage is not reset; access is only ever raised outside reset since state_q is IDLE then.
    always_ff @(posedge clk) begin
        if (access && write_q)
            for (int k = 0; k < NB; k++)
                mem_q[addr_q + ADDRESS_SIZE'(k)] <= wdata_q[WORD_SIZE-1-8*k -: 8];
    end

    assign req_ready  = state_q == IDLE;
    assign resp_valid = state_q == RESP;
    assign resp_rdata = rdata_q;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: scoreboard bench for mem_responder (WAIT_CYCLES=2 main instance, WAIT_CYCLES=0 latency instance)
module tb_mem_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_write = 1'b0, resp_ready = 1'b1;
    logic [10:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic        req_ready, resp_valid;
    logic [63:0] resp_rdata;
    logic        req_valid0 = 1'b0, req_write0 = 1'b0, resp_ready0 = 1'b1;
    logic [10:0] req_addr0 = '0;
    logic [63:0] req_wdata0 = '0;
    logic        req_ready0, resp_valid0;
    logic [63:0] resp_rdata0;
    int          checks = 0, errors = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    mem_responder #(.ADDRESS_SIZE(11), .WORD_SIZE(64), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata)
    );

    mem_responder #(.ADDRESS_SIZE(11), .WORD_SIZE(64), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid0), .req_ready(req_ready0),
        .req_write(req_write0), .req_addr(req_addr0), .req_wdata(req_wdata0),
        .resp_valid(resp_valid0), .resp_ready(resp_ready0), .resp_rdata(resp_rdata0)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every response handshake is compared against the oldest expected word.
    always @(negedge clk) begin
        if (!rst && resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL resp_unexpected: got %h expected none", resp_rdata);
            end else begin
                chk("resp_rdata", resp_rdata, exp_q.pop_front());
            end
        end
    end

    task automatic wait_resp(output int n);
        n = 0;
        while (!resp_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic txn(input logic w, input logic [10:0] a, input logic [63:0] d, input logic [63:0] exp);
        int n;
        chk("req_ready_idle", {63'd0, req_ready}, 64'd1);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
        exp_q.push_back(exp);
        @(posedge clk); #1;
        req_valid = 1'b0; req_write = ~w; req_addr = ~a; req_wdata = ~d;
        wait_resp(n);
        chk("latency", 64'(n), 64'd3);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [7:0]  wb [8];
        logic [10:0] ai;
        wb = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        #12;
        chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
        chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("rst_resp_rdata", resp_rdata, 64'd0);
        @(posedge clk); #1 rst = 1'b0;

        txn(1'b1, 11'h000, 64'h0102030405060708, 64'd0);
        txn(1'b1, 11'h008, 64'h090A0B0C0D0E0F10, 64'd0);
        txn(1'b0, 11'h000, 64'd0, 64'h0102030405060708);
        txn(1'b0, 11'h003, 64'd0, 64'h0405060708090A0B);

        txn(1'b1, 11'h010, 64'hDEADBEEFCAFEF00D, 64'd0);
        txn(1'b0, 11'h010, 64'd0, 64'hDEADBEEFCAFEF00D);
        chk("mem_010", {56'd0, dut.mem_q[11'h010]}, 64'hDE);
        chk("mem_017", {56'd0, dut.mem_q[11'h017]}, 64'h0D);

        txn(1'b1, 11'h7FC, 64'h1122334455667788, 64'd0);
        for (int i = 0; i < 8; i++) begin
            ai = 11'h7FC + 11'(i);
            chk("mem_wrap", {56'd0, dut.mem_q[ai]}, {56'd0, wb[i]});
        end
        txn(1'b0, 11'h7FC, 64'd0, 64'h1122334455667788);
        txn(1'b0, 11'h000, 64'd0, 64'h5566778805060708);

        resp_ready = 1'b0;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 11'h010;
        exp_q.push_back(64'hDEADBEEFCAFEF00D);
        @(posedge clk); #1 req_valid = 1'b0;
        wait_resp(n);
        chk("bp_latency", 64'(n), 64'd3);
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1; req_write = 1'b1; req_addr = 11'h010; req_wdata = 64'd0;
            chk("bp_resp_valid", {63'd0, resp_valid}, 64'd1);
            chk("bp_rdata", resp_rdata, 64'hDEADBEEFCAFEF00D);
            chk("bp_req_ready", {63'd0, req_ready}, 64'd0);
            @(posedge clk); #1;
        end
        req_valid = 1'b0; resp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_ready", {63'd0, req_ready}, 64'd1);
        chk("bp_release_valid", {63'd0, resp_valid}, 64'd0);
        txn(1'b0, 11'h010, 64'd0, 64'hDEADBEEFCAFEF00D);

        req_valid = 1'b1; req_write = 1'b0; req_addr = 11'h000;
        @(posedge clk); #1 req_valid = 1'b0;
        @(posedge clk); #3 rst = 1'b1;
        #1;
        chk("arst_req_ready", {63'd0, req_ready}, 64'd1);
        chk("arst_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("arst_resp_rdata", resp_rdata, 64'd0);
        @(posedge clk); #1 rst = 1'b0;

        txn(1'b1, 11'h020, 64'h0011223344556677, 64'd0);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 11'h020; req_wdata = 64'hFFFFFFFFFFFFFFFF;
        @(posedge clk); #1 req_valid = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        #1 chk("wrst_req_ready", {63'd0, req_ready}, 64'd1);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        txn(1'b0, 11'h020, 64'd0, 64'h0011223344556677);

        req_valid0 = 1'b1; req_write0 = 1'b1; req_addr0 = 11'h100; req_wdata0 = 64'h0123456789ABCDEF;
        @(posedge clk); #1 req_valid0 = 1'b0;
        chk("w0_busy_valid", {63'd0, resp_valid0}, 64'd0);
        @(posedge clk); #1;
        chk("w0_resp_valid", {63'd0, resp_valid0}, 64'd1);
        chk("w0_resp_rdata", resp_rdata0, 64'd0);
        @(posedge clk); #1;
        chk("w0_idle_ready", {63'd0, req_ready0}, 64'd1);
        req_valid0 = 1'b1; req_write0 = 1'b0; req_addr0 = 11'h100;
        @(posedge clk); #1 req_valid0 = 1'b0;
        @(posedge clk); #1;
        chk("r0_resp_valid", {63'd0, resp_valid0}, 64'd1);
        chk("r0_resp_rdata", resp_rdata0, 64'h0123456789ABCDEF);
        @(posedge clk); #1;

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
